// File: rtl/td4_prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : libloader (package)
// Purpose  : Shared constants and types for the TD4 program loader:
//            frame sync marker, memory depth, byte/address types and
//            the loader state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package libloader;

  localparam logic [7:0] c_SYNC_BYTE = 8'hA5;
  localparam int         c_DEPTH     = 16;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_FILL = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/td4_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : td4_prog_loader_if
// Purpose  : Byte-stream valid/ready channel feeding the program loader.
// Signals  : rx_data  - byte from source
//            rx_valid - rx_data is valid
//            rx_ready - sink accepts the byte this cycle
// Modports : master (byte source), slave (loader)
// Revision : 1.0 - initial release
// ============================================================================
interface td4_prog_loader_if;
  import libloader::*;

  byte_t rx_data;
  logic  rx_valid;
  logic  rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface
`default_nettype wire

// File: rtl/td4_prog_loader_ram.sv
`default_nettype none
// ============================================================================
// Module   : td4_prog_ram
// Purpose  : DEPTH x 8 instruction memory, one synchronous write port and
//            one asynchronous read port. Contents are not reset.
// Ports    : clk   - clock
//            we    - write enable
//            waddr - write address
//            wdata - write data
//            raddr - read address
//            rdata - read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module td4_prog_ram
  import libloader::*;
#(
  parameter int DEPTH = c_DEPTH
) (
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  byte_t wdata,
  input  addr_t raddr,
  output byte_t rdata
);

  byte_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : td4_prog_loader
// Purpose  : Receives a framed byte stream (SYNC, LEN, LEN data bytes, CSUM),
//            writes the TD4 instruction memory, zero-fills the unused tail
//            and releases the CPU with a one-cycle reset pulse.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            rx           - byte-stream slave channel
//            fetch_ip     - CPU instruction pointer
//            fetch_instr  - instruction at fetch_ip (asynchronous read)
//            cpu_hold     - CPU must not update state while high
//            cpu_rst      - one-cycle CPU register reset pulse
//            busy         - frame in progress
//            err          - sticky error from the last frame
// Revision : 1.0 - initial release
// ============================================================================
module td4_prog_loader
  import libloader::*;
#(
  parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE,
  parameter int         DEPTH     = c_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  td4_prog_loader_if.slave rx,
  input  addr_t            fetch_ip,
  output byte_t            fetch_instr,
  output logic             cpu_hold,
  output logic             cpu_rst,
  output logic             busy,
  output logic             err
);

  localparam logic [2:0] c_IDLE = ST_IDLE;
  localparam logic [2:0] c_LEN  = ST_LEN;
  localparam logic [2:0] c_DATA = ST_DATA;
  localparam logic [2:0] c_CSUM = ST_CSUM;
  localparam logic [2:0] c_FILL = ST_FILL;
  localparam logic [2:0] c_DONE = ST_DONE;

  logic [2:0] r_state;
  logic [4:0] r_len;     // 1..16, needs five bits
  addr_t      r_addr;
  byte_t      r_sum;
  logic       r_hold;
  logic       r_err;

  logic       w_ready;
  logic       w_accept;
  logic       w_we;
  byte_t      w_wdata;

  always_comb begin
    w_ready = (r_state == c_IDLE) || (r_state == c_LEN) ||
              (r_state == c_DATA) || (r_state == c_CSUM);
    w_we    = 1'b0;
    w_wdata = 8'h00;
    if (r_state == c_DATA && rx.rx_valid) begin
      w_we    = 1'b1;
      w_wdata = rx.rx_data;
    end else if (r_state == c_FILL) begin
      w_we    = 1'b1;
    end
  end

  assign w_accept = rx.rx_valid && w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_len   <= 5'd0;
      r_addr  <= 4'd0;
      r_sum   <= 8'h00;
      r_hold  <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept && rx.rx_data == SYNC_BYTE) begin
            r_state <= c_LEN;
            r_hold  <= 1'b1;
          end
        end
        c_LEN: begin
          if (w_accept) begin
            if (rx.rx_data >= 8'd1 && rx.rx_data <= 8'd16) begin
              r_len   <= rx.rx_data[4:0];
              r_addr  <= 4'd0;
              r_sum   <= 8'h00;
              r_state <= c_DATA;
            end else begin
              r_err   <= 1'b1;
              r_state <= c_IDLE;
            end
          end
        end
        c_DATA: begin
          if (w_accept) begin
            r_addr <= r_addr + 4'd1;
            r_sum  <= r_sum + rx.rx_data;
            if ({1'b0, r_addr} == r_len - 5'd1) begin
              r_state <= c_CSUM;
            end
          end
        end
        c_CSUM: begin
          // r_addr already points at entry N, the first one to zero-fill
          // (wrapped to 0 when N=16, in which case no fill is needed).
          if (w_accept) begin
            if (rx.rx_data == r_sum) begin
              r_err   <= 1'b0;
              r_state <= (r_len == 5'd16) ? c_DONE : c_FILL;
            end else begin
              r_err   <= 1'b1;
              r_state <= c_IDLE;
            end
          end
        end
        c_FILL: begin
          r_addr <= r_addr + 4'd1;
          if (r_addr == 4'd15) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_hold  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  td4_prog_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (w_wdata),
    .raddr (fetch_ip),
    .rdata (fetch_instr)
  );

  assign rx.rx_ready = w_ready;
  assign cpu_hold    = r_hold;
  assign cpu_rst     = (r_state == c_DONE);
  assign busy        = (r_state != c_IDLE);
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_td4_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_prog_loader
// Purpose  : Directed self-checking bench for td4_prog_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fetch_ip = 4'd0;
  logic [7:0] fetch_instr;
  logic       cpu_hold;
  logic       cpu_rst;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  td4_prog_loader_if rx_if ();

  td4_prog_loader u_dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx_if),
    .fetch_ip    (fetch_ip),
    .fetch_instr (fetch_instr),
    .cpu_hold    (cpu_hold),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    while (!rx_if.rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("send_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
  endtask

  task automatic chk_mem(input int a, input logic [7:0] e);
    fetch_ip = 4'(a);
    #1;
    check($sformatf("mem[%0d]", a), 32'(fetch_instr), 32'(e));
  endtask

  // Called #1 after CSUM acceptance; counts FILL cycles until cpu_rst.
  task automatic wait_done(input int exp_fill, input string tag);
    int n;
    n = 0;
    while (!cpu_rst && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_fill_cycles"}, 32'(n), 32'(exp_fill));
    check({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_rst_pulse_end"}, 32'(cpu_rst), 32'd0);
    check({tag, "_hold_released"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_err_after"}, 32'(err), 32'd0);
  endtask

  initial begin
    rx_if.rx_data  = 8'h00;
    rx_if.rx_valid = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(rx_if.rx_ready), 32'd1);
    send_byte(8'h00);
    check("idle_00_busy", 32'(busy), 32'd0);
    send_byte(8'hFF);
    check("idle_ff_busy", 32'(busy), 32'd0);

    // Good 3-byte frame
    send_byte(8'hA5);
    check("sync_busy", 32'(busy), 32'd1);
    send_byte(8'h03);
    send_byte(8'hB1);
    send_byte(8'h01);
    send_byte(8'hF0);
    send_byte(8'hA2);
    check("a_fill_ready", 32'(rx_if.rx_ready), 32'd0);
    wait_done(13, "a");
    chk_mem(0, 8'hB1);
    chk_mem(1, 8'h01);
    chk_mem(2, 8'hF0);
    for (int i = 3; i < 16; i++) chk_mem(i, 8'h00);
    chk_mem(1, 8'h01);

    // Bad checksum then good 1-byte frame
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h30);
    send_byte(8'h40);
    send_byte(8'h00);
    check("bad_csum_err", 32'(err), 32'd1);
    check("bad_csum_hold", 32'(cpu_hold), 32'd1);
    check("bad_csum_busy", 32'(busy), 32'd0);
    check("bad_csum_no_rst", 32'(cpu_rst), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hE5);
    send_byte(8'hE5);
    wait_done(15, "b");
    chk_mem(0, 8'hE5);
    chk_mem(1, 8'h00);

    // Illegal LEN values
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len00_err", 32'(err), 32'd1);
    check("len00_busy", 32'(busy), 32'd0);
    check("len00_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h01);
    send_byte(8'h30);
    check("len00_ignored", 32'(busy), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    check("len11_err", 32'(err), 32'd1);
    check("len11_busy", 32'(busy), 32'd0);
    send_byte(8'h02);
    send_byte(8'h03);
    check("len11_ignored", 32'(busy), 32'd0);

    // N=16 frame with gaps; data i*0x11, checksum 0xF8
    send_byte(8'hA5);
    send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1) begin
        @(posedge clk);
        #1;
      end
      send_byte(8'(i * 8'h11));
    end
    send_byte(8'hF8);
    // Hold a sync byte on the channel straight away
    rx_if.rx_data  = 8'hA5;
    rx_if.rx_valid = 1'b1;
    check("n16_done_now", 32'(cpu_rst), 32'd1);
    check("n16_ready_done", 32'(rx_if.rx_ready), 32'd0);
    check("n16_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    check("n16_idle_hold", 32'(cpu_hold), 32'd0);
    check("n16_idle_busy", 32'(busy), 32'd0);
    check("n16_idle_cpu_rst", 32'(cpu_rst), 32'd0);
    @(posedge clk);
    #1;
    rx_if.rx_valid = 1'b0;
    check("held_byte_consumed", 32'(busy), 32'd1);
    check("held_byte_hold", 32'(cpu_hold), 32'd1);
    chk_mem(5, 8'h55);
    chk_mem(15, 8'hFF);
    send_byte(8'h00);
    check("pre_rst_err", 32'(err), 32'd1);

    // Reset mid-frame after two data bytes
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_err", 32'(err), 32'd0);
    chk_mem(0, 8'h12);
    chk_mem(1, 8'h34);
    chk_mem(2, 8'h22);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h78);
    wait_done(14, "c");
    chk_mem(0, 8'hAB);
    chk_mem(1, 8'hCD);
    chk_mem(2, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
